control_input_decoder: RTL and testbench
========================================

Name: control_input_decoder

Overview:
- Front-panel input decoder for the scaler control path.
- Converts raw slide switches and zoom pushbuttons into a held algorithm selection, a zoom exponent, and the three error flags consumed by the seven-segment information display.
- Also produces a one-cycle apply strobe toward the scaler datapath.
- Sits between the board I/O pins and the control/display logic.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a key level is accepted (20 ms at 50 MHz)
MAX_ZOOM_EXP, 2, maximum magnitude of zoom_exp (2 = 4x up or 1/4 down)
ERR_TIMEOUT_CYCLES, 150000000, auto-clear delay for invalid_zoom_error (used only with the optional feature)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-low reset
SW  input  4  algorithm switches, one-hot intended; SW[0] nearest neighbor, SW[1] pixel replication, SW[2] decimation, SW[3] block averaging
KEY  input  2  pushbuttons, active-low; KEY[0] zoom in, KEY[1] zoom out
algorithm_select  output  2  held algorithm index, 00/01/10/11 = SW[0..3]
zoom_exp  output  3  two's-complement zoom exponent, range -MAX_ZOOM_EXP..+MAX_ZOOM_EXP
invalid_zoom_error  output  1  sticky flag; the last zoom request was rejected
multiple_switches_error  output  1  more than one SW bit is high
no_switch_selected_error  output  1  no SW bit is high
apply_pulse  output  1  one-cycle strobe; a new valid algorithm/zoom configuration is in effect

Behaviour:
- Reset (reset==0 sampled at posedge clk):
  - algorithm_select=00, zoom_exp=0.
  - All error flags=0, apply_pulse=0.
  - Synchronizers: SW=0000, KEY=11. Debounced key state=released. Counters=0. FSM=RUN.
- Synchronization: SW and KEY each pass through 2 flip-flops before any use.
- Debounce, per key:
  - The counter increments while the synced level differs from the accepted level; it clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears.
  - A press event is a 1-cycle pulse on an accepted 1->0 transition. Releases generate no event.
  - Glitches shorter than DEBOUNCE_CYCLES never produce an event.
- Switch decode (synced SW, combinational count, registered flags):
  - Count 0: no_switch_selected_error=1.
  - Count >1: multiple_switches_error=1.
  - The two flags are never both 1.
  - Flags follow the synced switches with 1 cycle of register latency.
- Algorithm change:
  - Occurs when SW is one-hot and its index differs from algorithm_select.
  - Next cycle: algorithm_select updates, zoom_exp clears to 0, invalid_zoom_error clears, apply_pulse=1.
  - During switch errors, algorithm_select and zoom_exp hold their last valid values.
- Zoom rules:
  - Upscaling algorithms 00/01 allow zoom_exp 0..+MAX_ZOOM_EXP.
  - Downscaling algorithms 10/11 allow -MAX_ZOOM_EXP..0.
  - Zoom-in request: valid if the result zoom_exp+1 stays inside the allowed range. Zoom-out request: valid if zoom_exp-1 stays inside it.
- FSM states:
  - RUN: a valid request updates zoom_exp in the following cycle with apply_pulse=1. An invalid request leaves zoom_exp unchanged, sets invalid_zoom_error=1, and moves to ZERR.
  - ZERR: invalid_zoom_error held at 1. The next valid zoom request or an algorithm change clears it and returns to RUN. A further invalid request stays in ZERR.
- Latency: from a clean raw KEY falling edge to the zoom_exp/apply_pulse update is exactly DEBOUNCE_CYCLES+3 clocks.
- Boundary cases:
  - Press events while either switch error is active are discarded: no zoom change, no invalid flag.
  - Both press events in the same cycle are treated as an invalid request.
  - An algorithm change and a press event in the same cycle: the algorithm change wins and the press is discarded.
  - zoom_exp never leaves the legal range; there is no wrap-around.
  - Reset asserted mid-debounce or mid-error restores all reset values on the next edge.

Optional Feature:
ZOOM_ERR_TIMEOUT_EN
- Defined: a counter runs while in ZERR. After ERR_TIMEOUT_CYCLES cycles with no new request, invalid_zoom_error clears and the FSM returns to RUN. Any new invalid request restarts the count.
- Undefined: invalid_zoom_error stays set until a valid request, an algorithm change, or reset. No timeout counter is synthesized.

Test Plan:
- Debounce/latency (DEBOUNCE_CYCLES=4): reset, SW=0010, KEY[0] low held 10 cycles -> apply_pulse at cycle 7 after edge, zoom_exp=+1. A 3-cycle KEY[0] glitch -> no change.
- Upper limit: SW=0001, three zoom-in presses -> zoom_exp 1, then 2, then invalid_zoom_error=1 with zoom_exp=2. A following zoom-out -> zoom_exp=1, error=0.
- Downscale algorithm: SW=0100, zoom-in press -> invalid_zoom_error=1, zoom_exp=0. Two zoom-out presses -> zoom_exp=-1 then -2 (3'b110).
- Switch errors: SW=0000 -> no_switch_selected_error=1, algorithm_select held. SW=1010 -> multiple_switches_error=1 and presses ignored. SW=1000 -> algorithm_select=11, zoom_exp=0, apply_pulse=1.
- Simultaneous events: both keys pressed in the same cycle -> invalid_zoom_error=1, no zoom change. SW edge and press in the same cycle -> algorithm change only.
- Reset mid-operation: zoom_exp=+2 in ZERR, reset=0 for 1 cycle -> all outputs at reset values. With ZOOM_ERR_TIMEOUT_EN and ERR_TIMEOUT_CYCLES=8 -> error clears 8 cycles after entering ZERR.

Source files
------------

// File: rtl/control_input_decoder.sv
// Front-panel input decoder for the scaler control path.
// Synchronizes and debounces the zoom keys, decodes the algorithm switches, tracks
// the zoom exponent, and raises the error flags and apply strobe.
// Optional build macro: ZOOM_ERR_TIMEOUT_EN (auto-clears invalid_zoom_error after
// ERR_TIMEOUT_CYCLES cycles spent in the zoom-error state).
module control_input_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES    = 1000000,
    parameter int unsigned MAX_ZOOM_EXP       = 2,
    parameter int unsigned ERR_TIMEOUT_CYCLES = 150000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] SW,
    input  logic [1:0] KEY,
    output logic [1:0] algorithm_select,
    output logic [2:0] zoom_exp,
    output logic       invalid_zoom_error,
    output logic       multiple_switches_error,
    output logic       no_switch_selected_error,
    output logic       apply_pulse
);

    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [3:0] MaxZ = 4'(MAX_ZOOM_EXP);

    typedef enum logic [0:0] {StRun, StZerr} state_e;

    logic [3:0]     sw_meta_q, sw_sync_q;
    logic [1:0]     key_meta_q, key_sync_q;
    logic [1:0]     key_acc_q, press_q;
    logic [DbW-1:0] db_cnt_q [2];
    logic           no_sw_q, multi_sw_q;
    logic [1:0]     alg_q;
    logic [2:0]     zoom_q;
    logic           apply_q;
    state_e         state_q, state_d;

    logic [2:0]        sw_count;
    logic              sw_onehot;
    logic [1:0]        sw_index;
    logic              alg_change, req_in, req_out, request, req_valid, req_invalid;
    logic signed [3:0] zoom_ext, zoom_hi, zoom_lo;

    // Two-flop synchronizers for the raw board inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sw_meta_q  <= 4'b0000;
            sw_sync_q  <= 4'b0000;
            key_meta_q <= 2'b11;
            key_sync_q <= 2'b11;
        end else begin
            sw_meta_q  <= SW;
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= KEY;
            key_sync_q <= key_meta_q;
        end
    end

    // Per-key debounce; press_q pulses for one cycle on an accepted 1->0 flip.
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_acc_q <= 2'b11;
            press_q   <= 2'b00;
            for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                press_q[k] <= 1'b0;
                if (key_sync_q[k] == key_acc_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DbLast) begin
                    key_acc_q[k] <= key_sync_q[k];
                    db_cnt_q[k]  <= '0;
                    press_q[k]   <= key_acc_q[k];
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Switch decode and zoom request qualification.
    always_comb begin
        sw_count = {2'b00, sw_sync_q[0]} + {2'b00, sw_sync_q[1]}
                 + {2'b00, sw_sync_q[2]} + {2'b00, sw_sync_q[3]};
        sw_onehot = (sw_count == 3'd1);
        case (sw_sync_q)
            4'b0010: sw_index = 2'd1;
            4'b0100: sw_index = 2'd2;
            4'b1000: sw_index = 2'd3;
            default: sw_index = 2'd0;
        endcase
        alg_change = sw_onehot && (sw_index != alg_q);
        // Presses are dropped during switch errors and lose to an algorithm change.
        req_in   = press_q[0] && sw_onehot && !alg_change;
        req_out  = press_q[1] && sw_onehot && !alg_change;
        request  = req_in || req_out;
        zoom_ext = {zoom_q[2], zoom_q};
        zoom_hi  = alg_q[1] ? 4'sd0 : MaxZ;
        zoom_lo  = alg_q[1] ? -MaxZ : 4'sd0;
        // z+1 <= hi  <=>  z < hi;  z-1 >= lo  <=>  z > lo.  Both keys at once is invalid.
        req_valid   = (req_in && !req_out && (zoom_ext < zoom_hi))
                   || (req_out && !req_in && (zoom_ext > zoom_lo));
        req_invalid = request && !req_valid;
    end

    // Registered switch error flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            no_sw_q    <= 1'b0;
            multi_sw_q <= 1'b0;
        end else begin
            no_sw_q    <= (sw_count == 3'd0);
            multi_sw_q <= (sw_count > 3'd1);
        end
    end

    // Held algorithm, zoom exponent and apply strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            alg_q   <= 2'd0;
            zoom_q  <= 3'd0;
            apply_q <= 1'b0;
        end else begin
            apply_q <= alg_change || req_valid;
            if (alg_change) begin
                alg_q  <= sw_index;
                zoom_q <= 3'd0;
            end else if (req_valid) begin
                zoom_q <= req_in ? zoom_q + 3'd1 : zoom_q - 3'd1;
            end
        end
    end

`ifdef ZOOM_ERR_TIMEOUT_EN
    localparam int unsigned ErrW = (ERR_TIMEOUT_CYCLES > 1) ? $clog2(ERR_TIMEOUT_CYCLES) : 1;
    localparam logic [ErrW-1:0] ErrLast = ErrW'(ERR_TIMEOUT_CYCLES - 1);

    logic [ErrW-1:0] err_cnt_q, err_cnt_d;
    logic            err_expired;

    // Timeout counter runs only while idling in the error state; any request restarts it.
    always_comb begin
        err_expired = (state_q == StZerr) && !request && (err_cnt_q == ErrLast);
        err_cnt_d   = '0;
        if (state_q == StZerr && !request && !alg_change && !err_expired) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (!reset) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= StRun;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (req_invalid) state_d = StZerr;
            end
            StZerr: begin
                if (alg_change || req_valid) state_d = StRun;
`ifdef ZOOM_ERR_TIMEOUT_EN
                else if (err_expired) state_d = StRun;
`endif
            end
            default: state_d = StRun;
        endcase
    end

    // FSM and datapath outputs.
    always_comb begin
        invalid_zoom_error       = (state_q == StZerr);
        algorithm_select         = alg_q;
        zoom_exp                 = zoom_q;
        multiple_switches_error  = multi_sw_q;
        no_switch_selected_error = no_sw_q;
        apply_pulse              = apply_q;
    end

endmodule

// File: tb/tb_control_input_decoder.sv
// Directed testbench for control_input_decoder (DEBOUNCE_CYCLES=4, ERR_TIMEOUT_CYCLES=8).
module tb_control_input_decoder;

`ifdef ZOOM_ERR_TIMEOUT_EN
    localparam bit TimeoutBuild = 1'b1;
`else
    localparam bit TimeoutBuild = 1'b0;
`endif

    typedef struct {
        logic [3:0] sw;
        logic [1:0] key;
        logic [1:0] alg;
        logic [2:0] zoom;
        logic       inv;
        logic       multi;
        logic       nosw;
        int         pulses;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] SW;
    logic [1:0] KEY;
    logic [1:0] algorithm_select;
    logic [2:0] zoom_exp;
    logic       invalid_zoom_error, multiple_switches_error, no_switch_selected_error;
    logic       apply_pulse;

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;
    vec_t vecs[18];

    control_input_decoder #(
        .DEBOUNCE_CYCLES   (4),
        .MAX_ZOOM_EXP      (2),
        .ERR_TIMEOUT_CYCLES(8)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .SW                      (SW),
        .KEY                     (KEY),
        .algorithm_select        (algorithm_select),
        .zoom_exp                (zoom_exp),
        .invalid_zoom_error      (invalid_zoom_error),
        .multiple_switches_error (multiple_switches_error),
        .no_switch_selected_error(no_switch_selected_error),
        .apply_pulse             (apply_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    function automatic vec_t mk(logic [3:0] sw, logic [1:0] key, logic [1:0] alg,
                                logic [2:0] zoom, logic inv, logic multi, logic nosw,
                                int np);
        vec_t v;
        v.sw = sw; v.key = key; v.alg = alg; v.zoom = zoom;
        v.inv = inv; v.multi = multi; v.nosw = nosw; v.pulses = np;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (apply_pulse) pulses++;
    endtask

    task automatic check_all(input int idx, input vec_t v);
        check("alg", idx, 32'(algorithm_select), 32'(v.alg));
        check("zoom", idx, 32'(zoom_exp), 32'(v.zoom));
        check("inv", idx, 32'(invalid_zoom_error), 32'(v.inv));
        check("multi", idx, 32'(multiple_switches_error), 32'(v.multi));
        check("nosw", idx, 32'(no_switch_selected_error), 32'(v.nosw));
    endtask

    // Set switches, optionally press keys; sample state one cycle after the press lands.
    task automatic run_op(input int idx, input vec_t v);
        @(negedge clk);
        SW = v.sw;
        pulses = 0;
        repeat (6) tick();
        if (v.key != 2'b11) begin
            @(negedge clk);
            KEY = v.key;
            repeat (8) tick();
            check_all(idx, v);
            @(negedge clk);
            KEY = 2'b11;
            repeat (10) tick();
        end else begin
            check_all(idx, v);
        end
        check("pulses", idx, 32'(pulses), 32'(v.pulses));
    endtask

    initial begin
        SW = 4'b0000;
        KEY = 2'b11;
        reset = 1'b0;

        //             sw       key    alg    zoom    inv  mul  nos  pulses
        vecs[0]  = mk(4'b0001, 2'b11, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1);
        vecs[1]  = mk(4'b0001, 2'b10, 2'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1);
        vecs[2]  = mk(4'b0001, 2'b10, 2'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1);
        vecs[3]  = mk(4'b0001, 2'b10, 2'd0, 3'b010, 1'b1, 1'b0, 1'b0, 0);
        vecs[4]  = mk(4'b0001, 2'b01, 2'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1);
        vecs[5]  = mk(4'b0100, 2'b11, 2'd2, 3'b000, 1'b0, 1'b0, 1'b0, 1);
        vecs[6]  = mk(4'b0100, 2'b10, 2'd2, 3'b000, 1'b1, 1'b0, 1'b0, 0);
        vecs[7]  = mk(4'b0100, 2'b01, 2'd2, 3'b111, 1'b0, 1'b0, 1'b0, 1);
        vecs[8]  = mk(4'b0100, 2'b01, 2'd2, 3'b110, 1'b0, 1'b0, 1'b0, 1);
        vecs[9]  = mk(4'b0100, 2'b01, 2'd2, 3'b110, 1'b1, 1'b0, 1'b0, 0);
        vecs[10] = mk(4'b0100, 2'b10, 2'd2, 3'b111, 1'b0, 1'b0, 1'b0, 1);
        vecs[11] = mk(4'b0000, 2'b11, 2'd2, 3'b111, 1'b0, 1'b0, 1'b1, 0);
        vecs[12] = mk(4'b0000, 2'b10, 2'd2, 3'b111, 1'b0, 1'b0, 1'b1, 0);
        vecs[13] = mk(4'b1010, 2'b11, 2'd2, 3'b111, 1'b0, 1'b1, 1'b0, 0);
        vecs[14] = mk(4'b1010, 2'b01, 2'd2, 3'b111, 1'b0, 1'b1, 1'b0, 0);
        vecs[15] = mk(4'b1000, 2'b11, 2'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1);
        vecs[16] = mk(4'b1000, 2'b00, 2'd3, 3'b000, 1'b1, 1'b0, 1'b0, 0);
        vecs[17] = mk(4'b1000, 2'b01, 2'd3, 3'b111, 1'b0, 1'b0, 1'b0, 1);

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_all(0, mk(4'b0000, 2'b11, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 0));
        check("rst_apply", 0, 32'(apply_pulse), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Latency: press lands exactly 7 edges after the raw falling edge.
        @(negedge clk);
        SW = 4'b0010;
        pulses = 0;
        repeat (8) tick();
        check("lat_alg", 0, 32'(algorithm_select), 32'd1);
        check("lat_alg_pulse", 0, 32'(pulses), 32'd1);
        @(negedge clk);
        KEY = 2'b10;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            if (c == 6) begin
                check("lat_apply6", c, 32'(apply_pulse), 32'd0);
                check("lat_zoom6", c, 32'(zoom_exp), 32'd0);
            end else if (c == 7) begin
                check("lat_apply7", c, 32'(apply_pulse), 32'd1);
                check("lat_zoom7", c, 32'(zoom_exp), 32'd1);
            end else if (c == 8) begin
                check("lat_apply8", c, 32'(apply_pulse), 32'd0);
            end
        end
        @(negedge clk);
        KEY = 2'b11;
        repeat (10) @(posedge clk);

        // 3-cycle glitch is filtered.
        @(negedge clk);
        KEY = 2'b10;
        pulses = 0;
        repeat (3) @(negedge clk);
        KEY = 2'b11;
        repeat (12) tick();
        check("glitch_pulse", 0, 32'(pulses), 32'd0);
        check("glitch_zoom", 0, 32'(zoom_exp), 32'd1);

        for (int i = 0; i < 18; i++) run_op(i, vecs[i]);

        // Algorithm change coincident with a press: change wins, press dropped.
        @(negedge clk);
        KEY = 2'b10;
        pulses = 0;
        repeat (4) @(negedge clk);
        SW = 4'b0001;
        repeat (6) tick();
        @(negedge clk);
        KEY = 2'b11;
        repeat (10) tick();
        check_all(100, mk(4'b0001, 2'b11, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1));
        check("coinc_pulses", 100, 32'(pulses), 32'd1);

        // Reset while at +2 in the error state.
        run_op(101, mk(4'b0001, 2'b10, 2'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1));
        run_op(102, mk(4'b0001, 2'b10, 2'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1));
        @(negedge clk);
        KEY = 2'b10;
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_inv", 103, 32'(invalid_zoom_error), 32'd1);
        check("pre_rst_zoom", 103, 32'(zoom_exp), 32'd2);
        @(negedge clk);
        reset = 1'b0;
        KEY = 2'b11;
        @(posedge clk);
        #1;
        check_all(104, mk(4'b0001, 2'b11, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 0));
        check("mid_rst_apply", 104, 32'(apply_pulse), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_all(105, mk(4'b0001, 2'b11, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 0));

        // Error persistence (or timeout in the optional build).
        @(negedge clk);
        KEY = 2'b01;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (c == 7 || c == 14) begin
                check("err_hold", c, 32'(invalid_zoom_error), 32'd1);
                check("err_zoom", c, 32'(zoom_exp), 32'd0);
            end else if (c == 15 || c == 30) begin
                check("err_timeout", c, 32'(invalid_zoom_error), TimeoutBuild ? 32'd0 : 32'd1);
            end
        end
        @(negedge clk);
        KEY = 2'b11;
        repeat (10) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
